// File: rtl/gr8ram_ctl_n.sv
// gr8ram_ctl_n: Apple II slot-card DRAM controller with an auto-stepping address window.
// A 3-bit 7M phase counter locks to PHI1 and interleaves one data access and CBR refresh per Apple cycle.
module gr8ram_ctl_n #(
    parameter int RA_W       = 11,
    parameter int BANK_LOG2  = 2,
    parameter int REF_PERIOD = 13
) (
    input  logic                        C7M,
    input  logic                        RES,
    input  logic                        PHI1,
    input  logic                        nDEVSEL,
    input  logic                        nIOSEL,
    input  logic                        nWE,
    input  logic [3:0]                  A,
    input  logic [7:0]                  D_i,
    output logic [7:0]                  D_o,
    output logic                        D_oe,
    input  logic [7:0]                  RD_i,
    output logic [7:0]                  RD_o,
    output logic                        RD_oe,
    output logic [RA_W-1:0]             RA,
    output logic                        nRAS,
    output logic [(1<<BANK_LOG2)-1:0]   nCAS,
    output logic                        nRWE
);

    localparam int ADDR_W = 2 * RA_W + BANK_LOG2;
    localparam int NB     = (ADDR_W + 7) / 8;
    localparam int NBANK  = 1 << BANK_LOG2;
    localparam logic [2:0] NB_L     = 3'(NB);
    localparam logic [3:0] REF_LAST = 4'(REF_PERIOD - 1);
    localparam logic [NBANK-1:0] BANK0_ONEHOT = {{(NBANK-1){1'b0}}, 1'b1};

    logic [2:0]        sR, sNext;
    logic              prevPhi1R, phi0SeenR, regEnR, dbenR;
    logic              accessR, accessNext, accWriteR, accWriteNext;
    logic              refreshR, refreshNext, stepPendR;
    logic [ADDR_W-1:0] addrR, addrNext, accAddrR, accAddrNext;
    logic [7:0]        stepR, stepNext;
    logic [3:0]        refCntR;
    logic              regSel, dataSel;
    logic              rasWin, casWin, refRasWin, refCasWin;
    logic [BANK_LOG2-1:0] bank;
    logic [RA_W-1:0]   raNext;
    logic [31:0]       addrWr, addrRd;
    logic [7:0]        rdData;

    assign regSel  = ~nDEVSEL & regEnR;
    assign dataSel = regSel & (A == 4'd8);

    // Phase counter: resync to 1 on a PHI1 rise seen after PHI0, else count up and saturate at 7.
    always_comb begin
        sNext = sR;
        if (PHI1 && !prevPhi1R && phi0SeenR) begin
            sNext = 3'd1;
        end else if (sR == 3'd0) begin
            sNext = 3'd0;
        end else if (sR == 3'd7) begin
            sNext = 3'd7;
        end else begin
            sNext = sR + 3'd1;
        end
    end

    // Per-cycle access/refresh flags and the strobe windows they open in the next phase.
    always_comb begin
        accessNext   = accessR;
        accWriteNext = accWriteR;
        accAddrNext  = accAddrR;
        refreshNext  = refreshR;
        if (sR == 3'd4) begin
            accessNext   = dataSel;
            accWriteNext = ~nWE;
            accAddrNext  = addrR;
        end else begin
            accessNext   = accessR;
        end
        if (sR == 3'd1) begin
            refreshNext = (refCntR == 4'd0);
        end else begin
            refreshNext = refreshR;
        end
        rasWin    = accessNext & (sNext >= 3'd5);
        casWin    = accessNext & (sNext >= 3'd6);
        refCasWin = refreshNext & (sNext >= 3'd2) & (sNext <= 3'd4);
        refRasWin = refreshNext & (sNext >= 3'd3) & (sNext <= 3'd4);
        bank      = accAddrNext[ADDR_W-1 -: BANK_LOG2];
        if (accessNext && (sNext == 3'd5)) begin
            raNext = accAddrNext[2*RA_W-1:RA_W];
        end else if (casWin) begin
            raNext = accAddrNext[RA_W-1:0];
        end else begin
            raNext = RA;
        end
    end

    // Address/STEP update: post-access step with full carry, or a register write at S6.
    always_comb begin
        addrWr   = 32'(addrR);
        addrNext = addrR;
        stepNext = stepR;
        if ((sR == 3'd7) && stepPendR) begin
            addrNext = addrR + {{(ADDR_W-8){stepR[7]}}, stepR};
        end else if ((sR == 3'd6) && regSel && !nWE) begin
            case (A)
                4'd0, 4'd1, 4'd2, 4'd3: begin
                    if ({1'b0, A[1:0]} < NB_L) begin
                        addrWr[{A[1:0], 3'b000} +: 8] = D_i;
                        addrNext = addrWr[ADDR_W-1:0];
                    end else begin
                        addrNext = addrR;
                    end
                end
                4'd9:    stepNext = D_i;
                default: addrNext = addrR;
            endcase
        end else begin
            addrNext = addrR;
        end
    end

    // Register readback mux; bytes beyond the address width read as zero.
    always_comb begin
        addrRd = 32'(addrR);
        rdData = 8'h00;
        case (A)
            4'd0, 4'd1, 4'd2, 4'd3: rdData = addrRd[{A[1:0], 3'b000} +: 8];
            4'd8:                   rdData = RD_i;
            4'd9:                   rdData = stepR;
            default:                rdData = 8'h00;
        endcase
    end

    assign D_oe  = dbenR & nWE & regSel;
    assign D_o   = (dbenR & regSel) ? rdData : 8'h00;
    assign RD_o  = D_i;
    assign RD_oe = dbenR & ~nWE & dataSel;

    // Controller state and registered DRAM strobes.
    always_ff @(posedge C7M or posedge RES) begin
        if (RES) begin
            sR        <= 3'd0;
            prevPhi1R <= 1'b0;
            phi0SeenR <= 1'b0;
            regEnR    <= 1'b0;
            dbenR     <= 1'b0;
            accessR   <= 1'b0;
            accWriteR <= 1'b0;
            accAddrR  <= {ADDR_W{1'b0}};
            refreshR  <= 1'b0;
            stepPendR <= 1'b0;
            addrR     <= {ADDR_W{1'b0}};
            stepR     <= 8'h01;
            refCntR   <= 4'd0;
            RA        <= {RA_W{1'b0}};
            nRAS      <= 1'b1;
            nCAS      <= {NBANK{1'b1}};
            nRWE      <= 1'b1;
        end else begin
            sR        <= sNext;
            prevPhi1R <= PHI1;
            if (!PHI1) begin
                phi0SeenR <= 1'b1;
            end
            if ((sR == 3'd4) && !nIOSEL) begin
                regEnR <= 1'b1;
            end
            if ((sR == 3'd4) && dataSel) begin
                stepPendR <= 1'b1;
            end else if (sR == 3'd7) begin
                stepPendR <= 1'b0;
            end
            if (sR == 3'd3) begin
                refCntR <= (refCntR == REF_LAST) ? 4'd0 : refCntR + 4'd1;
            end
            dbenR     <= (sNext >= 3'd4);
            accessR   <= accessNext;
            accWriteR <= accWriteNext;
            accAddrR  <= accAddrNext;
            refreshR  <= refreshNext;
            addrR     <= addrNext;
            stepR     <= stepNext;
            RA        <= raNext;
            nRAS      <= ~(rasWin | refRasWin);
            nCAS      <= ~({NBANK{refCasWin}} | ({NBANK{casWin}} & (BANK0_ONEHOT << bank)));
            nRWE      <= ~(rasWin & accWriteNext);
        end
    end

endmodule

// File: doc/gr8ram_ctl_n.md
Name: gr8ram_ctl_n

Overview:
Parametrised successor to the GR8RAM slot-card DRAM controller. It runs from one 7M clock and phase-locks to the Apple II PHI1 clock. It provides an auto-stepping address window into 2^ADDR_W bytes of DRAM split across 2^BANK_LOG2 CAS banks, and performs periodic CAS-before-RAS refresh. It sits between the Apple II slot bus (nDEVSEL/nIOSEL, D) and the DRAM array (RA, RD, nRAS, nCAS, nRWE).

Parameters:
RA_W, 11, DRAM multiplexed address width. Row = Addr[2*RA_W-1:RA_W], column = Addr[RA_W-1:0].
BANK_LOG2, 2, log2 of the number of CAS banks. Bank = Addr[ADDR_W-1 -: BANK_LOG2].
REF_PERIOD, 13, Apple cycles between refreshes (range 2..16).
Derived: ADDR_W = 2*RA_W + BANK_LOG2, which must be ≤32. NB = ceil(ADDR_W/8).

Ports:
C7M  in  1  7.16 MHz clock; all state changes on posedge.
RES  in  1  asynchronous, active-high reset.
PHI1  in  1  PHI1, already delayed and deglitched upstream.
nDEVSEL  in  1  slot device select (C0nX).
nIOSEL  in  1  slot ROM select (CnXX).
nWE  in  1  6502 R/W (1 = read).
A  in  4  6502 A[3:0].
D_i  in  8  Apple data bus in.
D_o  out  8  Apple data bus out.
D_oe  out  1  Apple data bus drive enable.
RD_i  in  8  DRAM data in.
RD_o  out  8  DRAM data out (equals D_i).
RD_oe  out  1  DRAM data drive enable.
RA  out  RA_W  DRAM address.
nRAS  out  1  row strobe.
nCAS  out  2^BANK_LOG2  per-bank column strobes.
nRWE  out  1  DRAM write enable.

Behaviour:
- Reset (RES=1, asynchronous): S=0, PHI0seen=0, REGEN=0, Addr=0, STEP=8'h01, refresh counter=0. Outputs: nRAS=1, nCAS=all 1, nRWE=1, D_oe=0, RD_oe=0, RA=0, D_o=0. Deasserting RES mid-access abandons the access with no increment.
- Phase counter S (3 bits):
  - PHI0seen sets on any edge with PHI1=0.
  - S←1 on an edge where PHI1=1, prev PHI1=0 and PHI0seen=1.
  - Otherwise S=0 holds at 0, S=7 saturates, and any other S increments.
- REGEN: sets at the S==4 edge if nIOSEL=0. Cleared only by reset. While REGEN=0, nDEVSEL accesses are ignored entirely.
- Register map (active when ~nDEVSEL & REGEN):
  - A=0..3: address bytes, LSB first. Bytes ≥ NB read 0, writes ignored. Bits above ADDR_W read 0.
  - A=8: data port.
  - A=9: STEP (signed 8-bit).
  - Other offsets: read 0, writes ignored.
- Register writes latch D_i at the S==6 edge.
- DBEN: registered, 1 for S∈{4,5,6,7}.
  - D_oe = DBEN & nWE & ~nDEVSEL & REGEN.
  - D_o = RD_i for the data port, else register readback.
  - RD_oe = DBEN & ~nWE & datasel.
- Data access (datasel sampled at the S==4 edge; it is the flag "access":
  - nRAS low for S5..S7, with RA=row during S5.
  - RA=column from S6.
  - nCAS[bank] low for S6..S7.
  - nRWE=nWE for S5..S7.
  - All strobes release at the S==1 edge, giving ≥1 7M cycle of precharge in S1.
- Post-access step: at the first S==7 edge after an access, Addr ← (Addr + sign-extended STEP) mod 2^ADDR_W, in a single cycle with full carry.
  - The step happens once per access.
  - STEP=0 holds Addr; 8'hFF decrements.
- Refresh:
  - The counter advances at each S==3 edge and wraps at REF_PERIOD-1→0.
  - When the counter is 0 at the S==1 edge: all nCAS low S2..S4, nRAS low S3..S4, all released at the S==5 edge.
  - Refresh never overlaps a data access, because the windows are disjoint.
- Unsynchronised (S==0): no strobes asserted and no refresh.
- Address-byte write vs. pending step: they cannot coincide (one access per Apple cycle). A write to an address byte never triggers a step.

Test Plan:
1. RES pulse, then 5 PHI1 cycles with no selects → S sequence 1..7 each cycle; refresh strobes occur every 13th cycle (nCAS=4'h0 S2..S4, nRAS low S3..S4).
2. IOSEL access, write 0x12,0x34,0x56 to A=0,1,2, then write 0xA5 at A=8 → bank=1 (nCAS=4'b1101), RA row=Addr[21:11], column=0x412; nRWE low S5..S7; Addr reads back 0x563413.
3. Read A=8 twice with STEP=1 → consecutive addresses; readback A=0 shows 0x14 then 0x15; D_o equals RD_i during S4..S7.
4. STEP=0xFF, Addr=0 → after one data read, Addr=0xFFFFFF (wrap), bank=3.
5. nDEVSEL access before any IOSEL access → D_oe=0, no RAS/CAS, Addr unchanged.
6. RES asserted at S6 of a write → nRAS/nCAS/nRWE high immediately, Addr=0 after release; re-sync on the next PHI1 rise after PHI0.
